// File: rtl/load_store_unit.sv
// Load/store unit: bridges a CPU load/store request onto a word-wide memory port.
// It handles byte-lane steering, load extension, alignment checks and an ack timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_ok;
    logic [31:0]       lane_data;
    logic [31:0]       load_data;
    logic [3:0]        be_mask;

    always_comb begin
        unique case (req_size)
            2'b00:   req_ok = 1'b1;
            2'b01:   req_ok = ~req_addr[0];
            2'b10:   req_ok = (req_addr[1:0] == 2'b00);
            default: req_ok = 1'b0;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by size.
    always_comb begin
        lane_data = mem_rdata >> {addr_q[1:0], 3'b000};
        unique case (size_q)
            2'b00:   load_data = zext_q ? {24'b0, lane_data[7:0]}
                                        : {{24{lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = zext_q ? {16'b0, lane_data[15:0]}
                                        : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'b00:   be_mask = 4'b0001 << addr_q[1:0];
            2'b01:   be_mask = 4'b0011 << addr_q[1:0];
            default: be_mask = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        zext_d  = zext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_ok) begin
                        state_d = StAccess;
                        we_d    = req_we;
                        size_d  = req_size;
                        zext_d  = req_unsigned;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        cnt_d   = '0;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            StAccess: begin
                // An ack arriving on the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : load_data;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        stall      = req_valid && (state_q != StResp);
        resp_valid = (state_q == StResp);
        resp_err   = (state_q == StResp) && err_q;
        resp_rdata = rdata_q;
        mem_req    = (state_q == StAccess);
        mem_we     = (state_q == StAccess) && we_q;
        mem_be     = (state_q == StAccess) ? be_mask : 4'b0000;
        mem_addr   = {addr_q[31:2], 2'b00};
        unique case (size_q)
            2'b00:   mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata = {2{wdata_q[15:0]}};
            default: mem_wdata = wdata_q;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scripted memory responder.
// The unit is built with TIMEOUT=4 so the abort path is short.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec;
    int n_err;

    int          obs_req_cycles;
    int          obs_resp_cnt;
    int          obs_resp_cyc;
    logic        obs_unstable;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic        obs_err;
    logic [31:0] obs_rdata;
    logic        obs_stall_resp;

    load_store_unit #(
        .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; ack on the ack_after'th mem_req cycle (0 = never ack).
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int ack_after, input logic [31:0] rdata);
        obs_req_cycles = 0;
        obs_resp_cnt   = 0;
        obs_resp_cyc   = -1;
        obs_unstable   = 1'b0;
        obs_be         = 4'h0;
        obs_addr       = '0;
        obs_wdata      = '0;
        obs_we         = 1'b0;
        obs_err        = 1'b0;
        obs_rdata      = 32'hDEADDEAD;
        obs_stall_resp = 1'b1;
        req_valid      = 1'b1;
        req_we         = we;
        req_size       = sz;
        req_unsigned   = uns;
        req_addr       = addr;
        req_wdata      = wd;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'hA5A5A5A5;
            if (mem_req) begin
                obs_req_cycles++;
                if (obs_req_cycles == 1) begin
                    obs_be    = mem_be;
                    obs_addr  = mem_addr;
                    obs_wdata = mem_wdata;
                    obs_we    = mem_we;
                end else if (mem_be != obs_be || mem_addr != obs_addr ||
                             mem_wdata != obs_wdata || mem_we != obs_we) begin
                    obs_unstable = 1'b1;
                end
                if (obs_req_cycles == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (resp_valid) begin
                obs_resp_cnt++;
                if (obs_resp_cnt == 1) begin
                    obs_err        = resp_err;
                    obs_rdata      = resp_rdata;
                    obs_stall_resp = stall;
                    obs_resp_cyc   = cyc;
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (obs_resp_cnt > 0) req_valid = 1'b0;
            if (obs_resp_cnt > 0 && cyc >= obs_resp_cyc + 2) break;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int rv_cnt;
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_val("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store, ack on the second access cycle
        txn(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 2, 32'h0);
        check_val("wst_be", {28'b0, obs_be}, 32'hF);
        check_val("wst_addr", obs_addr, 32'h40);
        check_val("wst_wdata", obs_wdata, 32'hDEADBEEF);
        check_val("wst_we", {31'b0, obs_we}, 32'd1);
        check_val("wst_req_cycles", obs_req_cycles, 32'd2);
        check_val("wst_stable", {31'b0, obs_unstable}, 32'd0);
        check_val("wst_resp_cnt", obs_resp_cnt, 32'd1);
        check_val("wst_err", {31'b0, obs_err}, 32'd0);
        check_val("wst_rdata", obs_rdata, 32'd0);
        check_val("wst_stall_resp", {31'b0, obs_stall_resp}, 32'd0);

        // Signed byte load from lane 3
        txn(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1, 32'h80FF0011);
        check_val("lbs_be", {28'b0, obs_be}, 32'h8);
        check_val("lbs_addr", obs_addr, 32'h40);
        check_val("lbs_we", {31'b0, obs_we}, 32'd0);
        check_val("lbs_rdata", obs_rdata, 32'hFFFFFF80);
        check_val("lbs_err", {31'b0, obs_err}, 32'd0);
        check_val("lbs_latency", obs_resp_cyc, 32'd2);
        check_val("lbs_hold", resp_rdata, 32'hFFFFFF80);
        check_val("lbs_idle_rv", {31'b0, resp_valid}, 32'd0);

        txn(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1, 32'h80FF0011);
        check_val("lbu_rdata", obs_rdata, 32'h00000080);

        // Halfword store to upper half
        txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1, 32'h0);
        check_val("sh_be", {28'b0, obs_be}, 32'hC);
        check_val("sh_wdata", obs_wdata, 32'h12341234);
        check_val("sh_addr", obs_addr, 32'h20);

        // Byte store to lane 1
        txn(1'b1, 2'b00, 1'b0, 32'h105, 32'h000000AB, 1, 32'h0);
        check_val("sb_be", {28'b0, obs_be}, 32'h2);
        check_val("sb_wdata", obs_wdata, 32'hABABABAB);
        check_val("sb_addr", obs_addr, 32'h104);

        // Signed halfword load from upper half
        txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1, 32'hBEEF1234);
        check_val("lhs_rdata", obs_rdata, 32'hFFFFBEEF);
        txn(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1, 32'hBEEF8234);
        check_val("lhu_rdata", obs_rdata, 32'h00008234);

        // Misaligned word load
        txn(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 1, 32'h0);
        check_val("mis_w_req", obs_req_cycles, 32'd0);
        check_val("mis_w_err", {31'b0, obs_err}, 32'd1);
        check_val("mis_w_lat", obs_resp_cyc, 32'd1);
        check_val("mis_w_rdata", obs_rdata, 32'd0);
        check_val("mis_w_cnt", obs_resp_cnt, 32'd1);

        txn(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 32'h0);
        check_val("mis_h_err", {31'b0, obs_err}, 32'd1);
        check_val("mis_h_req", obs_req_cycles, 32'd0);

        txn(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0);
        check_val("ill_err", {31'b0, obs_err}, 32'd1);
        check_val("ill_req", obs_req_cycles, 32'd0);

        // Timeout: no ack ever
        txn(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 0, 32'h0);
        check_val("to_req_cycles", obs_req_cycles, 32'd4);
        check_val("to_err", {31'b0, obs_err}, 32'd1);
        check_val("to_rdata", obs_rdata, 32'd0);
        check_val("to_resp_cnt", obs_resp_cnt, 32'd1);
        check_val("to_mem_req_after", {31'b0, mem_req}, 32'd0);

        // Ack on the last allowed cycle is a success
        txn(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 4, 32'hCAFEF00D);
        check_val("to4_req_cycles", obs_req_cycles, 32'd4);
        check_val("to4_err", {31'b0, obs_err}, 32'd0);
        check_val("to4_rdata", obs_rdata, 32'hCAFEF00D);

        // Stray ack while idle is ignored
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("stray_ack_rv", {31'b0, resp_valid}, 32'd0);
        check_val("stray_ack_req", {31'b0, mem_req}, 32'd0);

        // Reset in the middle of an access
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mid_pre", {31'b0, mem_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_req", {31'b0, mem_req}, 32'd0);
        check_val("rst_mid_be", {28'b0, mem_be}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        check_val("rst_mid_no_resp", rv_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Unit is usable again after reset
        txn(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1, 32'h00C30000);
        check_val("post_rst_rdata", obs_rdata, 32'h00000000);
        check_val("post_rst_be", {28'b0, obs_be}, 32'h2);
        txn(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1, 32'h00C30000);
        check_val("post_rst_lb", obs_rdata, 32'hFFFFFFC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port req_valid  input  1  CPU load/store request present.
REQ-005 Port req_we  input  1  1 = store, 0 = load.
REQ-006 Port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data, right-aligned.
REQ-010 Port stall  output  1  CPU must hold request stable while high.
REQ-011 Port resp_valid  output  1  one-cycle pulse; transaction complete.
REQ-012 Port resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-013 Port resp_err  output  1  valid with resp_valid; misaligned, illegal size or timeout.
REQ-014 Port mem_req  output  1  memory request, held until mem_ack.
REQ-015 Port mem_we  output  1  memory write enable.
REQ-016 Port mem_addr  output  32  word address: req_addr[31:2], 2'b00.
REQ-017 Port mem_wdata  output  32  store data replicated into byte lanes.
REQ-018 Port mem_be  output  4  byte enables, little-endian lane = addr[1:0].
REQ-019 Port mem_ack  input  1  memory completion strobe, one cycle.
REQ-020 Port mem_rdata  input  32  read word, valid when mem_ack.

Function
REQ-021 FSM states: IDLE, ACCESS, RESP; encoded in a registered state variable.
REQ-022 IDLE + req_valid + legal, aligned request -> ACCESS next cycle; latch we, size, unsigned, addr[1:0], wdata, addr.
REQ-023 Alignment: halfword requires addr[0]=0, word requires addr[1:0]=00; byte is always aligned.
REQ-024 IDLE + req_valid + misaligned or size 11 -> RESP with resp_err=1; mem_req never asserted.
REQ-025 ACCESS: mem_req=1, mem_we, mem_addr, mem_be, mem_wdata driven from latched values, all stable until mem_ack.
REQ-026 mem_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; loads drive the same mask.
REQ-027 mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-028 ACCESS + mem_ack -> RESP; load data captured from mem_rdata that cycle.
REQ-029 Load extraction: select lane(s) by latched addr[1:0]; extend to 32 bits per req_unsigned.
REQ-030 Timeout counter clears on IDLE->ACCESS and increments each ACCESS cycle without mem_ack; at TIMEOUT -> RESP with resp_err=1 and mem_req dropped.
REQ-031 mem_ack on the same cycle the counter reaches TIMEOUT is treated as success.
REQ-032 RESP lasts exactly one cycle: resp_valid=1, then IDLE.
REQ-033 stall = req_valid and (state != RESP); stall=0 in RESP so the CPU advances.
REQ-034 A new request is accepted no earlier than the cycle after RESP, so minimum latency is 3 cycles (IDLE, ACCESS with ack, RESP).
REQ-035 mem_ack outside ACCESS is ignored.
REQ-036 resp_rdata holds its last value outside RESP; it is 0 for stores and errors.

Reset
REQ-037 reset_n low asynchronously forces IDLE, mem_req=0, mem_we=0, mem_be=0, resp_valid=0, resp_err=0, resp_rdata=0, counter=0.
REQ-038 Reset during ACCESS abandons the transaction; no resp_valid is produced for it.

Verification
REQ-039 Word store addr 0x40, wdata 0xDEADBEEF, ack after 2 cycles -> mem_be=1111, mem_addr=0x40, resp_valid once, resp_err=0.
REQ-040 Signed byte load addr 0x43, mem_rdata 0x80FF0011 -> mem_be=1000, resp_rdata=0xFFFFFF80; with unsigned -> 0x00000080.
REQ-041 Halfword store addr 0x22, wdata 0x1234 -> mem_be=1100, mem_wdata=0x12341234.
REQ-042 Word load addr 0x41 -> no mem_req, resp_valid with resp_err=1 after 1 cycle.
REQ-043 TIMEOUT=4, no ack -> mem_req high 4 cycles then resp_err=1; ack at cycle 4 -> success.
REQ-044 reset_n low mid-ACCESS -> mem_req drops immediately, FSM in IDLE, no resp_valid.
